// File: rtl/mem_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_align_unit
// Purpose  : Splits MEM-stage loads/stores into aligned data-memory accesses
//            and returns one merged, extended response per request.
// Revision : 1.0 - initial release
// ============================================================================
module mem_align_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_LD0  = 3'd1;
  localparam logic [2:0] c_LD1  = 3'd2;
  localparam logic [2:0] c_ST   = 3'd3;
  localparam logic [2:0] c_RESP = 3'd4;

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_w0;
  logic [DATA_W-1:0]     r_rdata;
  logic [2:0]            r_funct3;
  logic [1:0]            r_k;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_legal;
  logic [1:0]            w_off;
  logic [2:0]            w_size;
  logic                  w_cross;
  logic                  w_st_aligned;
  logic                  w_st_last;
  logic [2*DATA_W-1:0]   w_pair;
  logic [DATA_W-1:0]     w_win;
  logic [DATA_W-1:0]     w_ld_result;
  logic [7:0]            w_st_byte;
  logic [DM_ADDRESS-3:0] w_word0;
  logic [DM_ADDRESS-3:0] w_word1;

  assign w_accept = req_valid && (r_state == c_IDLE) && (req_read || req_write);

  // A request with both flags set is treated as a load, so req_read alone decides.
  always_comb begin
    w_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = req_read;
      default:                w_legal = 1'b0;
    endcase
  end

  assign w_off = r_addr[1:0];

  always_comb begin
    w_size       = 3'd4;
    w_st_aligned = (w_off == 2'd0);
    case (r_funct3[1:0])
      2'b00: begin
        w_size       = 3'd1;
        w_st_aligned = 1'b1;
      end
      2'b01: begin
        w_size       = 3'd2;
        w_st_aligned = ~w_off[0];
      end
      default: begin
        w_size       = 3'd4;
        w_st_aligned = (w_off == 2'd0);
      end
    endcase
  end

  assign w_cross   = (({1'b0, w_off} + w_size) > 3'd4);
  assign w_st_last = w_st_aligned || (r_k == (w_size[1:0] - 2'd1));

  assign w_word0 = r_addr[DM_ADDRESS-1:2];
  assign w_word1 = w_word0 + {{(DM_ADDRESS-3){1'b0}}, 1'b1};

  // In LD0 the high word is irrelevant because only non-crossing loads finish there.
  assign w_pair = (r_state == c_LD1) ? {mem_rd, r_w0} : {{DATA_W{1'b0}}, mem_rd};
  assign w_win  = w_pair[{w_off, 3'b000} +: DATA_W];

  always_comb begin
    w_ld_result = w_win;
    case (r_funct3)
      3'b000:  w_ld_result = {{(DATA_W-8){w_win[7]}}, w_win[7:0]};
      3'b001:  w_ld_result = {{(DATA_W-16){w_win[15]}}, w_win[15:0]};
      3'b100:  w_ld_result = {{(DATA_W-8){1'b0}}, w_win[7:0]};
      3'b101:  w_ld_result = {{(DATA_W-16){1'b0}}, w_win[15:0]};
      default: w_ld_result = w_win;
    endcase
  end

  assign w_st_byte = r_wdata[{r_k, 3'b000} +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          if (!w_legal)      w_next = c_RESP;
          else if (req_read) w_next = c_LD0;
          else               w_next = c_ST;
        end
      end
      c_LD0:   w_next = w_cross ? c_LD1 : c_RESP;
      c_LD1:   w_next = c_RESP;
      c_ST:    w_next = w_st_last ? c_RESP : c_ST;
      c_RESP:  w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == c_IDLE);
    resp_valid = (r_state == c_RESP);
    resp_err   = (r_state == c_RESP) && r_err;
    resp_rdata = r_rdata;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    mem_funct3 = 3'b000;
    case (r_state)
      c_LD0: begin
        mem_read   = 1'b1;
        mem_funct3 = 3'b010;
        mem_addr   = {w_word0, 2'b00};
      end
      c_LD1: begin
        mem_read   = 1'b1;
        mem_funct3 = 3'b010;
        mem_addr   = {w_word1, 2'b00};
      end
      c_ST: begin
        mem_write = 1'b1;
        if (w_st_aligned) begin
          mem_addr   = r_addr;
          mem_funct3 = r_funct3;
          mem_wd     = r_wdata;
        end else begin
          mem_addr   = r_addr + {{(DM_ADDRESS-2){1'b0}}, r_k};
          mem_funct3 = 3'b000;
          mem_wd     = {{(DATA_W-8){1'b0}}, w_st_byte};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= 3'b000;
      r_k      <= 2'd0;
      r_w0     <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
            r_k      <= 2'd0;
            if (!w_legal) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
            end
          end
        end
        c_LD0: begin
          r_w0 <= mem_rd;
          if (!w_cross) begin
            r_rdata <= w_ld_result;
            r_err   <= 1'b0;
          end
        end
        c_LD1: begin
          r_rdata <= w_ld_result;
          r_err   <= 1'b0;
        end
        c_ST: begin
          r_k <= r_k + 2'd1;
          if (w_st_last) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_align_unit
// Purpose  : Scoreboard bench for mem_align_unit with a byte-level memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_align_unit;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MEM_BYTES = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_read, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [2:0]    req_funct3;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, mem_rd;
  logic [2:0]    mem_funct3;

  always #5 clk = ~clk;

  mem_align_unit #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  // Data memory seen by the DUT, and the bench's own view of what it should hold.
  logic [7:0] dmem    [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];

  always_comb begin
    mem_rd = {dmem[{mem_addr[8:2], 2'd3}], dmem[{mem_addr[8:2], 2'd2}],
              dmem[{mem_addr[8:2], 2'd1}], dmem[{mem_addr[8:2], 2'd0}]};
  end

  always @(posedge clk) begin
    if (mem_write) begin
      int n;
      n = (mem_funct3 == 3'b000) ? 1 : (mem_funct3 == 3'b001) ? 2 : 4;
      for (int i = 0; i < n; i++)
        dmem[(int'(mem_addr) + i) % MEM_BYTES] <= 8'(mem_wd >> (8 * i));
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  // Monitor: memory-port hygiene every cycle, response checking from the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      acc_cnt = 0;
    end else begin
      if (mem_read || mem_write) begin
        acc_cnt++;
        check("mem_rw_exclusive", 32'(mem_read & mem_write), 32'd0);
      end else begin
        check("mem_idle_zero", mem_wd | 32'(mem_addr) | 32'(mem_funct3), 32'd0);
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_resp: got resp_valid=1 expected none (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          check("resp_rdata", resp_rdata, mon_e.rdata);
          check("resp_err", 32'(resp_err), 32'(mon_e.err));
          check("resp_cycle", cyc, mon_e.cyc);
          check("mem_accesses", acc_cnt, mon_e.acc);
        end
        acc_cnt = 0;
      end
    end
  end

  task automatic wait_ready();
    int waitc;
    waitc = 0;
    while (!req_ready) begin
      @(posedge clk); #1;
      waitc++;
      if (waitc > 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ready_timeout: got req_ready=0 expected 1 within 50 cycles");
        finish_sim();
      end
    end
  endtask

  // Issue one request; the expected response is derived from byte-level memory rules.
  task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3);
    exp_t        e;
    int          sz, o;
    bit          legal, crossing, aligned;
    logic [31:0] v;
    wait_ready();
    req_valid  = 1'b1;
    req_read   = rd;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    req_funct3 = f3;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    o  = int'(addr) % 4;
    legal = rd ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
               : (f3 inside {3'b000, 3'b001, 3'b010});
    e.cyc = cyc;
    if (!legal) begin
      e.rdata = 32'd0; e.err = 1'b1; e.cyc += 1; e.acc = 0;
    end else if (rd) begin
      v = 32'd0;
      for (int i = 0; i < sz; i++)
        v |= 32'(ref_mem[(int'(addr) + i) % MEM_BYTES]) << (8 * i);
      if (f3 == 3'b000 && v[7])  v |= 32'hFFFF_FF00;
      if (f3 == 3'b001 && v[15]) v |= 32'hFFFF_0000;
      crossing = (o + sz > 4);
      e.rdata = v; e.err = 1'b0;
      e.cyc += crossing ? 3 : 2;
      e.acc  = crossing ? 2 : 1;
    end else begin
      for (int i = 0; i < sz; i++)
        ref_mem[(int'(addr) + i) % MEM_BYTES] = 8'(wd >> (8 * i));
      aligned = ((int'(addr) % sz) == 0);
      e.rdata = 32'd0; e.err = 1'b0;
      e.cyc += aligned ? 2 : sz + 1;
      e.acc  = aligned ? 1 : sz;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_read  = 1'b0;
    req_write = 1'b0;
  endtask

  initial begin
    int r;
    logic [2:0] f3;
    logic [AW-1:0] a;
    logic [2:0] legal_f3 [5];
    legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
    legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;

    for (int i = 0; i < MEM_BYTES; i++) begin
      dmem[i]    = 8'($urandom);
      ref_mem[i] = dmem[i];
    end
    reset = 1'b1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_funct3 = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_ctl", 32'({mem_read, mem_write, mem_funct3}), 32'd0);
    check("rst_mem_addr_wd", mem_wd | 32'(mem_addr), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Aligned store then load.
    do_req(1'b0, 1'b1, 9'h040, 32'h1122_3344, 3'b010);
    do_req(1'b1, 1'b0, 9'h040, 32'h0, 3'b010);
    // Word-crossing halfword, signed and unsigned.
    do_req(1'b0, 1'b1, 9'h040, 32'hAABB_CCDD, 3'b010);
    do_req(1'b0, 1'b1, 9'h044, 32'h1122_33EE, 3'b010);
    do_req(1'b1, 1'b0, 9'h043, 32'h0, 3'b001);
    do_req(1'b1, 1'b0, 9'h043, 32'h0, 3'b101);
    // Top-word wrap.
    do_req(1'b1, 1'b0, 9'h1FE, 32'h0, 3'b010);
    do_req(1'b0, 1'b1, 9'h1FF, 32'hCAFE_F00D, 3'b010);
    do_req(1'b1, 1'b0, 9'h1FD, 32'h0, 3'b010);
    // Misaligned word store, then aligned readback.
    do_req(1'b0, 1'b1, 9'h005, 32'hDEAD_BEEF, 3'b010);
    do_req(1'b1, 1'b0, 9'h004, 32'h0, 3'b010);
    do_req(1'b1, 1'b0, 9'h008, 32'h0, 3'b000);
    // Error paths and read+write treated as a load.
    do_req(1'b1, 1'b0, 9'h040, 32'h0, 3'b011);
    do_req(1'b0, 1'b1, 9'h040, 32'h5555_5555, 3'b100);
    do_req(1'b1, 1'b1, 9'h040, 32'h7777_7777, 3'b010);
    do_req(1'b1, 1'b1, 9'h041, 32'h0, 3'b110);

    // Valid without read or write is never accepted.
    wait_ready();
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("noop_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;

    // Reset during the second byte of a misaligned word store.
    wait_ready();
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
    req_addr = 9'h011; req_wdata = 32'h8765_4321; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
    check("mid_k0_write", 32'({mem_write, mem_addr}), 32'({1'b1, 9'h011}));
    ref_mem[9'h011] = 8'h21;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_mem_write", 32'(mem_write), 32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
    do_req(1'b1, 1'b0, 9'h014, 32'h0, 3'b010);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 3);
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
      a = ($urandom_range(0, 5) == 0) ? 9'(9'h1F8 + 9'($urandom_range(0, 7))) : 9'($urandom);
      do_req(r == 0 || r == 2, r != 0, a, $urandom, f3);
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    // Drain outstanding responses.
    for (int w = 0; w < 30 && sb.size() != 0; w++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d outstanding responses expected 0", sb.size());
    end
    repeat (2) @(posedge clk);
    finish_sim();
  end

endmodule
`default_nettype wire
